// File: rtl/alu_pkg.sv
// Shared ALU definitions: decoder FSM state encoding and default datapath width.
// No logic; types and constants only.
// Imported by the two's-complement decoder and its serial cell.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } tc_dec_state_t;

    localparam int TC_DEFAULT_WIDTH = 6;

endpackage

// File: rtl/tc_serial_cell.sv
// Per-bit two's-complement negation cell: copy bits up to and including the first 1, invert the rest.
// b_out is combinational from b_in; the seen_one flag updates on the clock edge.
// No handshake; the caller gates updates with en.
import alu_pkg::*;

module tc_serial_cell (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    input  logic neg,
    input  logic b_in,
    output logic b_out
);

    logic r_seen_one;

    // Track whether a 1 has already passed through; cleared at the start of each word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen_one <= 1'b0;
        end else if (start) begin
            r_seen_one <= 1'b0;
        end else if (en && neg) begin
            r_seen_one <= r_seen_one | b_in;
        end
    end

    // Positive words pass through; negative words invert every bit after the first 1
    always_comb begin
        b_out = b_in;
        if (neg && r_seen_one) begin
            b_out = ~b_in;
        end
    end

endmodule

// File: rtl/twos_complement_decoder.sv
// Bit-serial two's-complement to sign-magnitude converter, one bit per cycle LSB first.
// out_valid rises WIDTH cycles after the input acceptance edge.
// Holds the result in DONE while out_ready is low; in_ready is low outside IDLE.
import alu_pkg::*;

module twos_complement_decoder #(
    parameter int WIDTH = TC_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_zero
);

    tc_dec_state_t    r_state;
    tc_dec_state_t    w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;
    logic             r_out_sign;
    logic [WIDTH-1:0] r_out_mag;
    logic             r_out_zero;

    logic             w_accept;
    logic             w_conv;
    logic             w_last;
    logic             w_bit;
    logic [WIDTH-1:0] w_mag_next;

    assign w_accept   = (r_state == IDLE) && in_valid && !rst;
    assign w_conv     = (r_state == CONV);
    assign w_last     = w_conv && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_mag_next = {w_bit, r_acc[WIDTH-1:1]};

    tc_serial_cell u_cell (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .en    (w_conv),
        .neg   (r_neg),
        .b_in  (r_shift[0]),
        .b_out (w_bit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; in_ready is forced low while reset is held
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    w_state_next = CONV;
                end
            end
            CONV: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: load on acceptance, shift one bit per CONV cycle, publish on the last bit.
    // The published result lives in its own registers so it holds until the next DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_out_sign <= 1'b0;
            r_out_mag  <= '0;
            r_out_zero <= 1'b0;
        end else if (w_accept) begin
            r_shift <= in_data;
            r_neg   <= in_data[WIDTH-1];
            r_cnt   <= '0;
        end else if (w_conv) begin
            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            r_acc   <= w_mag_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_out_sign <= r_neg;
                r_out_mag  <= w_mag_next;
                r_out_zero <= (w_mag_next == '0);
            end
        end
    end

    assign out_sign = r_out_sign;
    assign out_mag  = r_out_mag;
    assign out_zero = r_out_zero;

endmodule
